// File: rtl/vram_dma.sv
// vram_dma: CPU-side copy engine that streams bytes from system memory into the GPU VRAM
// write port while holding the CPU off the bus, two clocks per byte.
module vram_dma #(
    parameter int VRAM_LIMIT = 'hD00,
    parameter int LEN_W      = 13
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        reg_sel_i,
    input  logic [2:0]  reg_addr_i,
    input  logic        reg_wen_i,
    input  logic [7:0]  reg_wdata_i,
    output logic [7:0]  reg_rdata_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [15:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        in_vblank_i,
    output logic [11:0] vram_address_o,
    output logic [7:0]  vram_data_o,
    output logic        vram_wen_o,
    output logic        select_pmf_o,
    output logic        select_pmb_o,
    output logic        select_ntbl_o,
    output logic        select_obm_o,
    output logic        select_txbl_o,
    output logic        done_irq_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        src_reg_q, src_reg_d;
    logic [11:0]        dst_reg_q, dst_reg_d;
    logic [LEN_W-1:0]   len_reg_q, len_reg_d;
    logic               wait_vb_q, wait_vb_d;
    logic [15:0]        src_q, src_d;
    logic [11:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               bus_req_q, bus_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               vram_wen_q, vram_wen_d;
    logic [11:0]        vram_addr_q, vram_addr_d;
    logic [4:0]         sel_q, sel_d;

    logic               ctrl_wr;
    logic               cfg_wr;
    logic [LEN_W:0]     dst_end;
    logic               over_limit;

    // One-hot region select, ordered {pmf, pmb, ntbl, obm, txbl}.
    function automatic logic [4:0] region_sel(input logic [11:0] a);
        if (a < 12'h200)      return 5'b10000;
        else if (a < 12'h400) return 5'b01000;
        else if (a < 12'h800) return 5'b00100;
        else if (a < 12'h900) return 5'b00010;
        else if (a < 12'hD00) return 5'b00001;
        else                  return 5'b00000;
    endfunction

    assign ctrl_wr    = reg_sel_i && reg_wen_i && (reg_addr_i == 3'd6);
    assign cfg_wr     = reg_sel_i && reg_wen_i && !busy_q;
    assign dst_end    = (LEN_W+1)'(dst_reg_q) + (LEN_W+1)'(len_reg_q);
    assign over_limit = dst_end > (LEN_W+1)'(VRAM_LIMIT);

    always_comb begin
        state_d   = state_q;
        src_reg_d = src_reg_q;
        dst_reg_d = dst_reg_q;
        len_reg_d = len_reg_q;
        wait_vb_d = wait_vb_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;

        // Configuration is frozen while a transfer owns the working copies.
        if (cfg_wr) begin
            unique case (reg_addr_i)
                3'd0: src_reg_d[7:0]        = reg_wdata_i;
                3'd1: src_reg_d[15:8]       = reg_wdata_i;
                3'd2: dst_reg_d[7:0]        = reg_wdata_i;
                3'd3: dst_reg_d[11:8]       = reg_wdata_i[3:0];
                3'd4: len_reg_d[7:0]        = reg_wdata_i;
                3'd5: len_reg_d[LEN_W-1:8]  = reg_wdata_i[LEN_W-9:0];
                3'd6: begin
                    wait_vb_d = reg_wdata_i[2];
                    if (reg_wdata_i[3]) begin
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_wr && reg_wdata_i[0] && !reg_wdata_i[1]) begin
                    error_d = 1'b0;
                    if (len_reg_q == '0) begin
                        done_d = 1'b1;
                    end else if (over_limit) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        src_d   = src_reg_q;
                        dst_d   = dst_reg_q;
                        len_d   = len_reg_q;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt_i && (!wait_vb_q || in_vblank_i)) state_d = S_READ;
            end
            S_READ: begin
                // Losing the bus here just re-issues the same source address later.
                if (!bus_gnt_i || (wait_vb_q && !in_vblank_i)) state_d = S_REQ;
                else                                           state_d = S_WRITE;
            end
            S_WRITE: begin
                src_d = src_q + 16'd1;
                dst_d = dst_q + 12'd1;
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ctrl_wr && reg_wdata_i[1]) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    // Outputs are registered against the state being entered, so they line up with state_q.
    always_comb begin
        bus_req_d   = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_WRITE);
        mem_addr_d  = (state_d == S_READ)  ? src_d : mem_addr_q;
        vram_wen_d  = (state_d == S_WRITE);
        vram_addr_d = (state_d == S_WRITE) ? dst_d : vram_addr_q;
        sel_d       = (state_d == S_WRITE) ? region_sel(dst_d) : 5'b00000;
    end

    // NOTE: synchronous reset sampled on the clock edge; all state uses non-blocking updates.
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            src_reg_q   <= '0;
            dst_reg_q   <= '0;
            len_reg_q   <= '0;
            wait_vb_q   <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            vram_wen_q  <= 1'b0;
            vram_addr_q <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_reg_q   <= src_reg_d;
            dst_reg_q   <= dst_reg_d;
            len_reg_q   <= len_reg_d;
            wait_vb_q   <= wait_vb_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            bus_req_q   <= bus_req_d;
            mem_addr_q  <= mem_addr_d;
            vram_wen_q  <= vram_wen_d;
            vram_addr_q <= vram_addr_d;
            sel_q       <= sel_d;
        end
    end

    always_comb begin
        reg_rdata_o = 8'h00;
        unique case (reg_addr_i)
            3'd0: reg_rdata_o = src_reg_q[7:0];
            3'd1: reg_rdata_o = src_reg_q[15:8];
            3'd2: reg_rdata_o = dst_reg_q[7:0];
            3'd3: reg_rdata_o = {4'h0, dst_reg_q[11:8]};
            3'd4: reg_rdata_o = len_reg_q[7:0];
            3'd5: reg_rdata_o = {{(16-LEN_W){1'b0}}, len_reg_q[LEN_W-1:8]};
            3'd6: reg_rdata_o = {5'b00000, error_q, done_q, busy_q};
            default: reg_rdata_o = 8'h00;
        endcase
    end

    assign bus_req_o      = bus_req_q;
    assign mem_addr_o     = mem_addr_q;
    assign vram_wen_o     = vram_wen_q;
    assign vram_address_o = vram_addr_q;
    // Read data arrives in the write cycle itself and is forwarded straight to the GPU.
    assign vram_data_o    = vram_wen_q ? mem_rdata_i : 8'h00;
    assign select_pmf_o   = sel_q[4];
    assign select_pmb_o   = sel_q[3];
    assign select_ntbl_o  = sel_q[2];
    assign select_obm_o   = sel_q[1];
    assign select_txbl_o  = sel_q[0];
    assign done_irq_o     = done_q;

endmodule
